// File: rtl/excess_to_binary_if.sv
// Digit-word bus for the excess-3 decoder: source drives in_valid/X, decoder returns B/err.
// err_count exists only when EXCESS_ERRCNT_EN is defined.
interface excess_to_binary_if #(parameter int DIGITS = 1);
  logic                  in_valid;
  logic [4*DIGITS-1:0]   X;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   B;
  logic [DIGITS-1:0]     err;
  logic                  any_err;
`ifdef EXCESS_ERRCNT_EN
  logic [7:0]            err_count;
`endif

`ifdef EXCESS_ERRCNT_EN
  modport master (output in_valid, X, input out_valid, B, err, any_err, err_count);
  modport slave  (input in_valid, X, output out_valid, B, err, any_err, err_count);
`else
  modport master (output in_valid, X, input out_valid, B, err, any_err);
  modport slave  (input in_valid, X, output out_valid, B, err, any_err);
`endif
endinterface

// File: rtl/excess_to_binary.sv
// Registered excess-3 to binary decoder, DIGITS independent digits per beat, 1-cycle latency.
// Optional saturating bad-beat counter enabled by EXCESS_ERRCNT_EN.
module excess_to_binary #(
  parameter int DIGITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  excess_to_binary_if.slave   bus
);

  logic [4*DIGITS-1:0] w_b;
  logic [DIGITS-1:0]   w_err;

  logic                r_valid;
  logic [4*DIGITS-1:0] r_b;
  logic [DIGITS-1:0]   r_err;
  logic                r_any_err;

  // Wrapping 4-bit subtract per digit; illegal codes still produce the wrapped value.
  always_comb begin
    w_b   = '0;
    w_err = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_b[4*i +: 4] = bus.X[4*i +: 4] - 4'd3;
      w_err[i]      = (bus.X[4*i +: 4] < 4'd3) || (bus.X[4*i +: 4] > 4'd12);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_b       <= '0;
      r_err     <= '0;
      r_any_err <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_b       <= w_b;
        r_err     <= w_err;
        r_any_err <= |w_err;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.B         = r_b;
  assign bus.err       = r_err;
  assign bus.any_err   = r_any_err;

`ifdef EXCESS_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (bus.in_valid && (|w_err) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.err_count = r_err_count;
`endif

endmodule

// File: tb/tb_excess_to_binary.sv
// Randomized and directed bench for excess_to_binary at DIGITS=1 and DIGITS=4,
// checked against an arithmetic reference model (err_count too when EXCESS_ERRCNT_EN is defined).
module tb_excess_to_binary;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  excess_to_binary_if #(.DIGITS(1)) bus1 ();
  excess_to_binary_if #(.DIGITS(4)) bus4 ();

  excess_to_binary #(.DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  excess_to_binary #(.DIGITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_checks = 0;
  int n_errors = 0;

  // expected registered state, index 0 = DIGITS=1 instance, 1 = DIGITS=4 instance
  int e_valid [2];
  int e_b     [2];
  int e_err   [2];
  int e_cnt   [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_b(input int x, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      int d = (x >> (4*i)) % 16;
      r += (((d - 3) + 16) % 16) << (4*i);
    end
    return r;
  endfunction

  function automatic int ref_err(input int x, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      int d = (x >> (4*i)) % 16;
      if (d < 3 || d > 12) r += (1 << i);
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = 0; e_b[k] = 0; e_err[k] = 0; e_cnt[k] = 0;
    end
  endtask

  task automatic model_beat(input int k, input int v, input int x, input int n);
    e_valid[k] = v;
    if (v != 0) begin
      e_b[k]   = ref_b(x, n);
      e_err[k] = ref_err(x, n);
      if (e_err[k] != 0 && e_cnt[k] < 255) e_cnt[k]++;
    end
  endtask

  task automatic compare_all();
    check_val("d1.out_valid", 32'(bus1.out_valid), 32'(e_valid[0]));
    check_val("d1.B",         32'(bus1.B),         32'(e_b[0]));
    check_val("d1.err",       32'(bus1.err),       32'(e_err[0]));
    check_val("d1.any_err",   32'(bus1.any_err),   32'(e_err[0] != 0));
    check_val("d4.out_valid", 32'(bus4.out_valid), 32'(e_valid[1]));
    check_val("d4.B",         32'(bus4.B),         32'(e_b[1]));
    check_val("d4.err",       32'(bus4.err),       32'(e_err[1]));
    check_val("d4.any_err",   32'(bus4.any_err),   32'(e_err[1] != 0));
`ifdef EXCESS_ERRCNT_EN
    check_val("d1.err_count", 32'(bus1.err_count), 32'(e_cnt[0]));
    check_val("d4.err_count", 32'(bus4.err_count), 32'(e_cnt[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      model_beat(0, int'(bus1.in_valid), int'(bus1.X), 1);
      model_beat(1, int'(bus4.in_valid), int'(bus4.X), 4);
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v1, input logic [3:0] x1, input logic v4, input logic [15:0] x4);
    bus1.in_valid = v1; bus1.X = x1;
    bus4.in_valid = v4; bus4.X = x4;
  endtask

  initial begin
    model_clear();
    drive(1'b0, 4'h0, 1'b0, 16'h0);
    #1 rst = 1'b1;
    #1;
    compare_all();
    tick();
    tick();
    rst = 1'b0;

    // exhaustive single-digit sweep plus wrap back to 0
    for (int x = 0; x <= 16; x++) begin
      drive(1'b1, 4'(x % 16), 1'b1, 16'($urandom));
      tick();
    end
    check_val("sweep.wrap_B", 32'(bus1.B), 32'd13);

    // valid gating
    drive(1'b1, 4'h8, 1'b0, 16'h0);
    tick();
    check_val("gate.B", 32'(bus1.B), 32'd5);
    drive(1'b0, 4'hF, 1'b0, 16'hFFFF);
    for (int i = 0; i < 3; i++) tick();
    check_val("gate.hold_B", 32'(bus1.B), 32'd5);
    check_val("gate.valid", 32'(bus1.out_valid), 32'd0);

    // multi-digit directed
    drive(1'b0, 4'h0, 1'b1, 16'hC963);
    tick();
    check_val("multi.B1", 32'(bus4.B), 32'h9630);
    check_val("multi.err1", 32'(bus4.err), 32'h0);
    drive(1'b0, 4'h0, 1'b1, 16'h3F03);
    tick();
    check_val("multi.B2", 32'(bus4.B), 32'h0CD0);
    check_val("multi.err2", 32'(bus4.err), 32'h6);
    check_val("multi.any2", 32'(bus4.any_err), 32'h1);

    // back-to-back alternating beats
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2 == 0) ? 4'h3 : 4'hC, 1'b1, (i % 2 == 0) ? 16'h3333 : 16'hCCCC);
      tick();
      check_val("b2b.B", 32'(bus1.B), (i % 2 == 0) ? 32'd0 : 32'd9);
    end

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 3) != 0), 16'($urandom));
      tick();
    end

`ifdef EXCESS_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'h0, 1'b1, 16'h0000);
      tick();
    end
    check_val("cnt.sat1", 32'(bus1.err_count), 32'd255);
    check_val("cnt.sat4", 32'(bus4.err_count), 32'd255);
`endif

    // asynchronous reset mid-cycle with a live beat
    drive(1'b1, 4'h5, 1'b1, 16'h5555);
    #3 rst = 1'b1;
    #1;
    model_clear();
    compare_all();
    check_val("rst.valid", 32'(bus1.out_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("rst.B_after", 32'(bus1.B), 32'd2);
    check_val("rst.B4_after", 32'(bus4.B), 32'h2222);
    drive(1'b0, 4'h0, 1'b0, 16'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
